// File: rtl/stepper_pkg.sv
// Shared types and sizing helpers for the stepper H-bridge output stage.
package stepper_pkg;

  typedef enum logic [1:0] {
    LEG_OFF,
    LEG_DEAD,
    LEG_ON
  } leg_state_t;

  localparam int DEAD_CYC_DEF = 50;

  // Bits needed to hold 0..n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hbridge_deadtime_if.sv
// Bundle of the bridge control inputs and gate/status outputs.
interface hbridge_deadtime_if;
  logic       en;
  logic [1:0] phase;
  logic       a_p;
  logic       a_n;
  logic       b_p;
  logic       b_n;
  logic [1:0] settled;
  logic       holding;

  modport master (
    output en, phase,
    input  a_p, a_n, b_p, b_n, settled, holding
  );

  modport slave (
    input  en, phase,
    output a_p, a_n, b_p, b_n, settled, holding
  );
endinterface

// File: rtl/hbridge_deadtime_leg.sv
// One H-bridge leg: OFF/DEAD/ON sequencer producing a complementary p/n pair
// with break-before-make dead time. Outputs are registered.
module hbridge_leg
  import stepper_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tgt,
  input  logic pwm_gate,
  output logic p,
  output logic n,
  output logic settled
);

  localparam int DEAD_W = cnt_w(DEAD_CYC);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

  leg_state_t        state, state_d;
  logic [DEAD_W-1:0] cnt, cnt_d;
  logic              side, side_d;
  logic              p_d, n_d, settled_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state;
    cnt_d     = cnt;
    side_d    = side;
    p_d       = 1'b0;
    n_d       = 1'b0;
    settled_d = 1'b0;

    if (!en) begin
      state_d = LEG_OFF;
    end else begin
      unique case (state)
        LEG_OFF: begin
          state_d = LEG_DEAD;
          cnt_d   = DEAD_LOAD;
        end
        LEG_DEAD: begin
          // Toggles of tgt are ignored here; the side is sampled only at expiry.
          if (cnt == '0) begin
            state_d = LEG_ON;
            side_d  = tgt;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        LEG_ON: begin
          if (tgt != side) begin
            state_d = LEG_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        default: state_d = LEG_OFF;
      endcase
    end

    // Only one side can be selected, so p and n are mutually exclusive by construction.
    if (state_d == LEG_ON) begin
      settled_d = 1'b1;
      p_d       = side_d & pwm_gate;
      n_d       = ~side_d & pwm_gate;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // values from before the edge regardless of statement order.
    if (rst) begin
      state   <= LEG_OFF;
      cnt     <= '0;
      side    <= 1'b0;
      p       <= 1'b0;
      n       <= 1'b0;
      settled <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      side    <= side_d;
      p       <= p_d;
      n       <= n_d;
      settled <= settled_d;
    end
  end

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver with dead time: input synchronisers, two legs and the
// optional hold-current chopper (enabled by defining HOLD_PWM_EN).
module hbridge_deadtime
  import stepper_pkg::*;
#(
  parameter int DEAD_CYC   = DEAD_CYC_DEF,
  parameter int IDLE_CYC   = 5_000_000,
  parameter int PWM_PERIOD = 1000,
  parameter int HOLD_DUTY  = 300
) (
  input logic               CLOCK_50,
  input logic               RESET,
  hbridge_deadtime_if.slave bus
);

  if (DEAD_CYC < 1 || IDLE_CYC < 1 || PWM_PERIOD < 1 ||
      HOLD_DUTY < 0 || HOLD_DUTY > PWM_PERIOD) begin : g_bad_cfg
    $error("hbridge_deadtime: invalid timing parameters");
  end

  // Two-flop synchronisers for the asynchronous enable and phase inputs.
  logic       en_s1, en_s2;
  logic [1:0] ph_s1, ph_s2;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
      ph_s1 <= 2'b00;
      ph_s2 <= 2'b00;
    end else begin
      en_s1 <= bus.en;
      en_s2 <= en_s1;
      ph_s1 <= bus.phase;
      ph_s2 <= ph_s1;
    end
  end

  logic       pwm_gate;
  logic [1:0] settled_w;
  logic       a_p_w, a_n_w, b_p_w, b_n_w;

`ifdef HOLD_PWM_EN
  localparam int IW = cnt_w(IDLE_CYC);
  localparam int PW = cnt_w(PWM_PERIOD);

  logic [1:0]    ph_q;
  logic [IW-1:0] idle_cnt;
  logic [PW-1:0] pwm_cnt;
  logic          hold_q;
  logic          phase_chg;
  logic          hold_set;

  assign phase_chg = (ph_s2 != ph_q);
  // Same-cycle view as the legs: a phase change or en drop releases hold on the edge the leg leaves ON.
  assign hold_set  = en_s2 && !phase_chg && (&settled_w) && (idle_cnt == IW'(IDLE_CYC));
  assign pwm_gate  = !hold_q || (pwm_cnt < PW'(HOLD_DUTY));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ph_q     <= 2'b00;
      idle_cnt <= '0;
      pwm_cnt  <= '0;
      hold_q   <= 1'b0;
    end else begin
      ph_q   <= ph_s2;
      hold_q <= hold_set;

      if (phase_chg)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_CYC))
        idle_cnt <= idle_cnt + 1'b1;

      // Restart the chop period on hold entry so the first window is a full on-time.
      if ((hold_set && !hold_q) || pwm_cnt == PW'(PWM_PERIOD - 1))
        pwm_cnt <= '0;
      else
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign bus.holding = hold_q;
`else
  assign pwm_gate    = 1'b1;
  assign bus.holding = 1'b0;
`endif

  hbridge_leg #(.DEAD_CYC(DEAD_CYC)) u_leg_a (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .en       (en_s2),
    .tgt      (ph_s2[0]),
    .pwm_gate (pwm_gate),
    .p        (a_p_w),
    .n        (a_n_w),
    .settled  (settled_w[0])
  );

  hbridge_leg #(.DEAD_CYC(DEAD_CYC)) u_leg_b (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .en       (en_s2),
    .tgt      (ph_s2[1]),
    .pwm_gate (pwm_gate),
    .p        (b_p_w),
    .n        (b_n_w),
    .settled  (settled_w[1])
  );

  assign bus.a_p     = a_p_w;
  assign bus.a_n     = a_n_w;
  assign bus.b_p     = b_p_w;
  assign bus.b_n     = b_n_w;
  assign bus.settled = settled_w;

endmodule
